// File: rtl/az_pkg.sv
// Shared definitions for the az_*/za_* request interface and its on-chip responder.
package az_pkg;

  localparam int unsigned AZ_ADDR_W = 22;
  localparam int unsigned AZ_DATA_W = 16;
  localparam int unsigned AZ_BE_W   = 2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } az_resp_state_t;

  function automatic logic az_req_present(input logic cs, input logic rd_n, input logic wr_n);
    return cs & (~rd_n | ~wr_n);
  endfunction

endpackage

// File: rtl/az_mem_responder_if.sv
// Request/response bundle between an az_* initiator and a responder such as az_mem_responder.
interface az_mem_responder_if
  import az_pkg::*;
#(
  parameter int unsigned ADDR_W = AZ_ADDR_W,
  parameter int unsigned DATA_W = AZ_DATA_W,
  parameter int unsigned BE_W   = AZ_BE_W
) ();

  logic              az_cs;
  logic              az_rd_n;
  logic              az_wr_n;
  logic [BE_W-1:0]   az_be_n;
  logic [ADDR_W-1:0] az_addr;
  logic [DATA_W-1:0] az_data;
  logic              za_valid;
  logic [DATA_W-1:0] za_data;
  logic              za_wait;

  modport master (
    output az_cs, az_rd_n, az_wr_n, az_be_n, az_addr, az_data,
    input  za_valid, za_data, za_wait
  );

  modport slave (
    input  az_cs, az_rd_n, az_wr_n, az_be_n, az_addr, az_data,
    output za_valid, za_data, za_wait
  );

endinterface

// File: rtl/az_bram.sv
// Single-port byte-enabled RAM with a registered read; storage is never reset.
module az_bram #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned BE_W       = 2,
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [BE_W-1:0]       be_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  rvalid_o
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Output register holds its value between reads so za_data stays stable.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= re_i;
      if (re_i) begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;

endmodule

// File: rtl/az_mem_responder.sv
// BRAM-backed az_* responder with programmable wait-states, read latency and a sticky
// protocol-error flag for simultaneous read/write requests.
module az_mem_responder
  import az_pkg::*;
#(
  parameter int unsigned ADDR_W      = AZ_ADDR_W,
  parameter int unsigned DATA_W      = AZ_DATA_W,
  parameter int unsigned BE_W        = AZ_BE_W,
  parameter int unsigned DEPTH_LOG2  = 8,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned RD_LATENCY  = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  az_mem_responder_if.slave  bus_io,
  output logic               proto_err_o
);

  localparam logic [0:0] StIdle   = ST_IDLE;
  localparam logic [0:0] StWait   = ST_WAIT;
  localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES);
  localparam bit         HasWait  = (WAIT_CYCLES != 0);

  logic [0:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       za_wait_q;
  logic       proto_err_q;

  logic req, illegal, accept, rd_acc, wr_acc;
  logic [DATA_W-1:0] bram_data;
  logic              bram_vld;

  // Upper address bits only alias onto the same storage.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus_io.az_addr[ADDR_W-1:DEPTH_LOG2];

  assign req     = az_req_present(bus_io.az_cs, bus_io.az_rd_n, bus_io.az_wr_n);
  assign illegal = bus_io.az_cs & ~bus_io.az_rd_n & ~bus_io.az_wr_n;
  assign accept  = req & ~illegal & ~za_wait_q & ~reset_i;
  assign rd_acc  = accept & ~bus_io.az_rd_n;
  assign wr_acc  = accept & ~bus_io.az_wr_n;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept && HasWait) begin
          state_d = StWait;
          cnt_d   = WaitLoad;
        end
      end
      StWait: begin
        if (cnt_q == 4'd1) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // za_wait sits high in reset so no request is taken before the first idle edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      za_wait_q   <= 1'b1;
      proto_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      za_wait_q <= (state_d == StWait);
      if (illegal && !za_wait_q) begin
        proto_err_q <= 1'b1;
      end
    end
  end

  az_bram #(
    .DATA_W     (DATA_W),
    .BE_W       (BE_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_bram (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .we_i     (wr_acc),
    .re_i     (rd_acc),
    .be_i     (~bus_io.az_be_n),
    .addr_i   (bus_io.az_addr[DEPTH_LOG2-1:0]),
    .wdata_i  (bus_io.az_data),
    .rdata_o  (bram_data),
    .rvalid_o (bram_vld)
  );

  if (RD_LATENCY == 1) begin : g_direct
    assign bus_io.za_valid = bram_vld;
    assign bus_io.za_data  = bram_data;
  end else begin : g_pipe
    localparam int unsigned Stages = RD_LATENCY - 1;

    logic [Stages-1:0] vld_q;
    logic [DATA_W-1:0] data_q [Stages];

    // Each data stage loads only behind a valid so the output holds between reads.
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        vld_q <= '0;
        for (int i = 0; i < int'(Stages); i++) begin
          data_q[i] <= '0;
        end
      end else begin
        vld_q[0] <= bram_vld;
        if (bram_vld) begin
          data_q[0] <= bram_data;
        end
        for (int i = 1; i < int'(Stages); i++) begin
          vld_q[i] <= vld_q[i-1];
          if (vld_q[i-1]) begin
            data_q[i] <= data_q[i-1];
          end
        end
      end
    end

    assign bus_io.za_valid = vld_q[Stages-1];
    assign bus_io.za_data  = data_q[Stages-1];
  end

  assign bus_io.za_wait = za_wait_q;
  assign proto_err_o    = proto_err_q;

endmodule

// File: doc/az_mem_responder.md
# az_mem_responder

On-chip responder for the system-side `az_*`/`za_*` request interface, the same protocol our SDRAM controller accepts. It is backed by byte-enabled block RAM and has configurable wait-states and read latency. It lets the switch/LED front-end and other request initiators be brought up and regression-tested without SDRAM, and it serves as the protocol reference for initiator-side checking.

## Interface
Parameters:
- `ADDR_W`, 22: request address width; only the low `DEPTH_LOG2` bits index storage.
- `DATA_W`, 16: data width. Must equal `8*BE_W`.
- `BE_W`, 2: byte-enable width.
- `DEPTH_LOG2`, 8: storage depth is 2^DEPTH_LOG2 words.
- `WAIT_CYCLES`, 1: `za_wait` high cycles after each accepted command. Range 0..15.
- `RD_LATENCY`, 2: cycles from read acceptance edge to the `za_valid` cycle. Range 1..8.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: sole clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `az_cs` in 1: chip select; no request is seen when low.
- `az_rd_n` in 1: read request, active low.
- `az_wr_n` in 1: write request, active low.
- `az_be_n` in BE_W: byte enables, active low, bit i selects `az_data[8i+7:8i]`.
- `az_addr` in ADDR_W: word address.
- `az_data` in DATA_W: write data.
- `za_valid` out 1: one-cycle pulse per read, qualifies `za_data`.
- `za_data` out DATA_W: read data, held until the next `za_valid`.
- `za_wait` out 1: registered; request must be held while high.
- `proto_err` out 1: sticky flag, cleared only by reset.

## Operation
- Request present: `az_cs & (~az_rd_n | ~az_wr_n)`.
- Accept: a request is present at a rising edge with `za_wait==0`. Exactly one command is accepted per such edge.
- Both `az_rd_n` and `az_wr_n` low with `az_cs` high is illegal. The request is not accepted, no state change occurs, and `proto_err` is set. `za_wait` is unaffected.
- Write: at the acceptance edge, `mem[az_addr[DEPTH_LOG2-1:0]]` bytes with `az_be_n[i]==0` are updated; other bytes keep their values. `az_be_n==2'b11` is a legal no-op write and still consumes wait-states.
- Read: returns the full word regardless of `az_be_n`. Bytes that are masked are not zeroed.
- Upper address bits `[ADDR_W-1:DEPTH_LOG2]` are ignored; addresses wrap modulo depth.
- Storage is not reset, so contents are undefined until written.
- FSM `ST_IDLE`/`ST_WAIT`:
  - In IDLE, `za_wait=0`.
  - An accept with `WAIT_CYCLES>0` moves to WAIT, loads the counter with `WAIT_CYCLES`, and sets `za_wait=1` from the next cycle.
  - WAIT decrements the counter each cycle. On the count reaching 1 it returns to IDLE, so `za_wait` is high for exactly `WAIT_CYCLES` cycles.
  - With `WAIT_CYCLES==0` the FSM stays in IDLE and accepts every cycle.
- Reads are pipelined: a valid shift register of depth `RD_LATENCY` carries outstanding reads. With zero wait-states, multiple reads may be in flight.

## Timing
- Reset values: `za_wait=1`, `za_valid=0`, `za_data=0`, `proto_err=0`, state IDLE, counter 0, read pipeline cleared.
- `za_wait` falls at the first edge with `reset` low. The first accept can occur at the following edge.
- Read accepted at edge N: `za_valid=1` and `za_data` valid in the cycle after edge N+RD_LATENCY-1. With `RD_LATENCY=1`, data appears one cycle after acceptance.
- Write then read to the same address, accepted at consecutive edges: the read returns the new data, with no forwarding hazard.
- Throughput: one command per `WAIT_CYCLES+1` cycles.
- Reset asserted mid-operation: in-flight reads are discarded, so no `za_valid` appears for them. A write already accepted has committed; no write is partially applied.
- `proto_err` sets at the edge where the illegal request is sampled and `za_wait==0`.

## Structure
- Package `az_pkg`:
  - `AZ_ADDR_W=22`, `AZ_DATA_W=16`, `AZ_BE_W=2`.
  - State enum `az_resp_state_t {ST_IDLE, ST_WAIT}`.
  - Function `az_req_present(cs, rd_n, wr_n)`.
- Sub-module `az_bram`: single-port, byte-enabled RAM with a one-cycle registered read. The top level adds `RD_LATENCY-1` data/valid stages, the FSM, and error logic.

## Test plan
- Reset then idle: hold `reset` 3 cycles, release. Expect `za_wait` = 1 through reset, 0 the first cycle after release; `za_valid` = 0 throughout.
- Byte-masked write/read (WAIT_CYCLES=1, RD_LATENCY=2):
  - Write 0xA5C3 to addr 0x05 with `be_n=00`.
  - Write 0x1100 to addr 0x05 with `be_n=10`.
  - Read addr 0x05.
  - Expect `za_data=0xA500` exactly 2 cycles after read acceptance, and `za_valid` high for one cycle.
- Back-to-back reads (WAIT_CYCLES=0, RD_LATENCY=3):
  - Preload addresses 0..3 with 0x0010..0x0013.
  - Issue 4 reads on consecutive cycles.
  - Expect 4 consecutive `za_valid` pulses with data in order, first pulse 3 cycles after the first accept.
- Wait-state hold (WAIT_CYCLES=3):
  - Write 0x1234 to addr 0x07, then hold a write of 0xBEEF to addr 0x00 continuously.
  - Expect `za_wait` high 3 cycles after the first accept, then the second write accepted.
  - A subsequent read of addr 0x07 returns 0x1234; a read of addr 0x00 returns 0xBEEF.
- Address wrap and illegal request (DEPTH_LOG2=8):
  - Write 0x00FF to addr 0x3_0105, then read addr 0x005. Expect 0x00FF.
  - Drive `az_rd_n=az_wr_n=0` with `az_cs=1`. Expect `proto_err=1` and memory unchanged.
- Reset mid-read (RD_LATENCY=4): assert `reset` 2 cycles after read acceptance. Expect no `za_valid`, `za_data=0`, and `proto_err` cleared.
